// File: rtl/sdp_ram_arbiter_pkg.sv
// sdp_ram_arbiter_pkg: FSM type, size limits and the byte-merge helper shared by the arbiter files
package sdp_ram_arbiter_pkg;
    localparam int MAX_NREQ = 8;
    localparam int MAX_DW = 256;
    localparam int MAX_BW = MAX_DW / 8;
    typedef enum logic {ARB_S, RMW_S} state_t;
    function automatic logic [MAX_DW-1:0] be_merge(
        input logic [MAX_DW-1:0] wdata,
        input logic [MAX_DW-1:0] rdata,
        input logic [MAX_BW-1:0] be
    );
        be_merge = rdata;
        for (int i = 0; i < MAX_BW; i++)
            if (be[i]) be_merge[i*8 +: 8] = wdata[i*8 +: 8];
    endfunction
endpackage

// File: rtl/sdp_ram_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant, scanning upward from a pointer that follows the last winner
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt
);
    localparam int PW = $clog2(NREQ);
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_j;
    logic [PW:0]   w_s;
    logic          w_found;
    always_comb begin
        o_gnt = '0;
        w_idx = '0;
        w_j = '0;
        w_s = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_s = {1'b0, r_ptr} + (PW+1)'(k);
            w_j = w_s >= (PW+1)'(NREQ) ? PW'(w_s - (PW+1)'(NREQ)) : PW'(w_s);
            if (i_en && !w_found && i_req[w_j]) begin
                w_found = 1'b1;
                o_gnt[w_j] = 1'b1;
                w_idx = w_j;
            end
        end
    end
    always_ff @(posedge HCLK)
        if (HRESET) r_ptr <= '0;
        else if (w_found) r_ptr <= w_idx == PW'(NREQ-1) ? '0 : w_idx + PW'(1);
endmodule

// File: rtl/sdp_ram_arbiter.sv
// sdp_ram_arbiter: round-robin sharing of one simple-dual-port RAM, byte-masked writes done as read-modify-write
module sdp_ram_arbiter
    import sdp_ram_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    localparam int BE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_write,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NREQ*BE_WIDTH-1:0]   req_be,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [ADDR_WIDTH-1:0]      wa,
    output logic                       we,
    output logic [DATA_WIDTH-1:0]      wd,
    output logic [ADDR_WIDTH-1:0]      ra,
    output logic                       re,
    input  logic [DATA_WIDTH-1:0]      rd
);
    if (NREQ < 2 || NREQ > MAX_NREQ || DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_params
        $error("sdp_ram_arbiter: unsupported parameter set");
    end
    state_t                r_state;
    logic                  r_we;
    logic                  r_hit;
    logic [ADDR_WIDTH-1:0] r_wa;
    logic [DATA_WIDTH-1:0] r_wd;
    logic [DATA_WIDTH-1:0] r_hit_data;
    logic [BE_WIDTH-1:0]   r_be;
    logic [NREQ-1:0]       r_rvalid;
    logic [NREQ-1:0]       w_gnt;
    logic                  w_rmw;
    logic                  w_any;
    logic                  w_write;
    logic                  w_full;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_fwd_rd;
    logic [BE_WIDTH-1:0]   w_be;
    assign w_rmw = r_state == RMW_S;
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .i_req  (req),
        .i_en   (!w_rmw && !HRESET),
        .o_gnt  (w_gnt)
    );
    always_comb begin
        w_write = 1'b0;
        w_addr = '0;
        w_wdata = '0;
        w_be = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_gnt[i]) begin
                w_write = req_write[i];
                w_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_be = req_be[i*BE_WIDTH +: BE_WIDTH];
            end
    end
    assign w_any = |w_gnt;
    assign w_full = &w_be;
    assign gnt = w_gnt;
    // Partial writes use the read port in the grant cycle to fetch the old word
    assign re = w_any && !(w_write && w_full);
    assign ra = w_addr;
    // RAM reads old data when written in the same cycle; the bypass supplies the new word
    assign w_fwd_rd = r_hit ? r_hit_data : rd;
    assign rdata = w_fwd_rd;
    assign rvalid = HRESET ? '0 : r_rvalid;
    assign we = !HRESET && (r_we || w_rmw);
    assign wa = r_wa;
    assign wd = w_rmw ? DATA_WIDTH'(be_merge(MAX_DW'(r_wd), MAX_DW'(w_fwd_rd), MAX_BW'(r_be))) : r_wd;
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= ARB_S;
            r_we <= 1'b0;
            r_rvalid <= '0;
            r_hit <= 1'b0;
        end else begin
            r_state <= w_any && w_write && !w_full ? RMW_S : ARB_S;
            r_we <= w_any && w_write && w_full;
            r_rvalid <= w_any && !w_write ? w_gnt : '0;
            r_hit <= re && we && ra == wa;
        end
        r_hit_data <= wd;
        if (w_any && w_write) begin
            r_wa <= w_addr;
            r_wd <= w_wdata;
            r_be <= w_be;
        end
    end
endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// tb_sdp_ram_arbiter: directed and random requests checked against a grant-order memory model
module tb_sdp_ram_arbiter;
    localparam int N = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    logic            HCLK = 1'b0;
    logic            HRESET = 1'b1;
    logic [N-1:0]    req, req_write, gnt, rvalid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*BW-1:0] req_be;
    logic [DW-1:0]   rdata, wd, rd;
    logic [AW-1:0]   wa, ra;
    logic            we, re;
    logic [DW-1:0]   ram [256];
    logic            bd_en = 1'b0;
    logic [AW-1:0]   bd_a;
    logic [DW-1:0]   bd_d;
    logic [DW-1:0]   mm [256];
    int              ptr = 0;
    bit              busy = 0;
    bit              rnd = 0;
    bit              p_v [N];
    bit              p_w [N];
    logic [AW-1:0]   p_a [N];
    logic [DW-1:0]   p_d [N];
    logic [BW-1:0]   p_be [N];
    logic [N-1:0]    e_rv = '0;
    logic [DW-1:0]   e_rd;
    bit              e_we = 0;
    logic [AW-1:0]   e_wa;
    logic [DW-1:0]   e_wd, e_old, saved;
    int              checks = 0;
    int              errors = 0;

    sdp_ram_arbiter #(.NREQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .req(req), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .wa(wa), .we(we), .wd(wd), .ra(ra), .re(re), .rd(rd)
    );

    always #5 HCLK = ~HCLK;

    // Read-first synchronous RAM, plus a backdoor port used only while in reset
    always @(posedge HCLK) begin
        if (re) rd <= ram[ra];
        if (we) ram[wa] <= wd;
        else if (bd_en) ram[bd_a] <= bd_d;
    end

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] d, input logic [DW-1:0] o, input logic [BW-1:0] be);
        for (int b = 0; b < BW; b++) merge[b*8 +: 8] = be[b] ? d[b*8 +: 8] : o[b*8 +: 8];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        p_v[i] = 1;
        p_w[i] = w;
        p_a[i] = a;
        p_d[i] = d;
        p_be[i] = be;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rnd && !p_v[i] && $urandom_range(0, 99) < 60)
                set(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 2) == 0 ? '1 : BW'($urandom_range(0, 15)));
            req[i] = p_v[i];
            req_write[i] = p_w[i];
            req_addr[i*AW +: AW] = p_a[i];
            req_wdata[i*DW +: DW] = p_d[i];
            req_be[i*BW +: BW] = p_be[i];
        end
    endtask

    // One clock: drive, check at the falling edge, then advance the model in grant order
    task automatic cycle();
        logic [N-1:0] eg;
        int win;
        bit ere;
        drive();
        @(negedge HCLK);
        win = -1;
        ere = 0;
        if (!HRESET && !busy)
            for (int k = 0; k < N; k++)
                if (win < 0 && p_v[(ptr + k) % N]) win = (ptr + k) % N;
        eg = win >= 0 ? N'(1) << win : '0;
        if (win >= 0) ere = !(p_w[win] && p_be[win] == '1);
        chk("gnt", DW'(gnt), DW'(eg));
        chk("re", DW'(re), DW'(ere));
        if (ere) chk("ra", DW'(ra), DW'(p_a[win]));
        chk("we", DW'(we), DW'(e_we && !HRESET));
        if (e_we && !HRESET) begin
            chk("wa", DW'(wa), DW'(e_wa));
            chk("wd", wd, e_wd);
        end
        chk("rvalid", DW'(rvalid), HRESET ? '0 : DW'(e_rv));
        if (!HRESET && e_rv != '0) chk("rdata", rdata, e_rd);
        if (HRESET) begin
            if (e_we) mm[e_wa] = e_old;
            ptr = 0;
            busy = 0;
            e_rv = '0;
            e_we = 0;
        end else begin
            busy = 0;
            e_rv = '0;
            e_we = 0;
            if (win >= 0) begin
                ptr = (win + 1) % N;
                if (p_w[win]) begin
                    e_old = mm[p_a[win]];
                    e_wd = merge(p_d[win], e_old, p_be[win]);
                    mm[p_a[win]] = e_wd;
                    e_wa = p_a[win];
                    e_we = 1;
                    busy = p_be[win] != '1;
                end else begin
                    e_rv = eg;
                    e_rd = mm[p_a[win]];
                end
                p_v[win] = 0;
            end
        end
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            p_v[i] = 0; p_w[i] = 0; p_a[i] = '0; p_d[i] = '0; p_be[i] = '0;
        end
        drive();
        for (int a = 0; a < 256; a++) begin
            bd_en = 1'b1;
            bd_a = AW'(a);
            bd_d = a == 'h10 ? 32'hDEADBEEF : a == 'h20 ? 32'hAABBCCDD : $urandom;
            mm[a] = bd_d;
            @(posedge HCLK);
            #1;
        end
        bd_en = 1'b0;
        cycle();
        HRESET = 1'b0;
        // Single read with latency 1
        set(0, 0, 8'h10, '0, '0);
        cycle();
        cycle();
        // Two readers in contention
        for (int c = 0; c < 6; c++) begin
            if (!p_v[0]) set(0, 0, AW'($urandom_range(0, 255)), '0, '0);
            if (!p_v[1]) set(1, 0, AW'($urandom_range(0, 255)), '0, '0);
            cycle();
        end
        p_v[0] = 0;
        p_v[1] = 0;
        cycle();
        // Partial write as read-modify-write, then read back
        set(1, 1, 8'h20, 32'h11223344, 4'b0100);
        cycle();
        set(0, 0, 8'h20, '0, '0);
        cycle();
        cycle();
        cycle();
        chk("rmw_word", ram[8'h20], 32'hAA22CCDD);
        // Full write followed immediately by a read of the same word
        set(0, 1, 8'h30, 32'hCAFEF00D, 4'hF);
        cycle();
        set(1, 0, 8'h30, '0, '0);
        cycle();
        chk("bypass_rdata", rdata, 32'hCAFEF00D);
        cycle();
        // Reset during the modify cycle abandons the write
        saved = ram[8'h40];
        set(0, 1, 8'h40, 32'h55555555, 4'b0001);
        cycle();
        HRESET = 1'b1;
        set(0, 0, 8'h41, '0, '0);
        set(1, 0, 8'h42, '0, '0);
        cycle();
        HRESET = 1'b0;
        cycle();
        chk("rmw_abandoned", ram[8'h40], saved);
        cycle();
        cycle();
        // Pointer wraps 3 -> 0, then a lone requester streams without bubbles
        set(2, 0, 8'h01, '0, '0);
        cycle();
        set(3, 0, 8'h02, '0, '0);
        cycle();
        for (int c = 0; c < 6; c++) begin
            set(0, 0, AW'($urandom_range(0, 255)), '0, '0);
            cycle();
        end
        cycle();
        // Random traffic on a small address window
        rnd = 1;
        repeat (400) cycle();
        rnd = 0;
        repeat (30) cycle();
        for (int a = 0; a < 256; a++) chk("mem", ram[a], mm[a]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
